hex_mode_router: RTL and testbench
==================================

Name: hex_mode_router

Overview:
- Parametrised, clocked successor to the combinational 3-mode HEX/KEY multiplexer.
- Selects one of N_MODES display sources (clock, stopwatch, timer, ...) for the seven-segment bank.
- Routes the physical push-keys only to the selected mode's key inputs.
- Cycles modes on a mode-button press, with a blanking interval and a key-release holdoff so stray presses never leak into the newly selected mode.

Parameters:
- N_MODES, 3: number of selectable sources; must be >= 2.
- N_DIGITS, 6: seven-segment digits per source.
- SEG_W, 7: segment bits per digit; active-low, all-ones = blank.
- N_KEYS, 3: routed push-keys; active-low, 1 = released.
- BLANK_CYCLES, 4: clock cycles the display is blanked after a mode change; must be >= 1.
- MIW, $clog2(N_MODES): mode index width (derived).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: synchronous active-low reset.
- mode_btn_n, in, 1: debounced mode button, active-low.
- keys_n, in, N_KEYS: debounced physical keys, active-low.
- hex_in, in, N_MODES*N_DIGITS*SEG_W: flattened sources. Source m, digit d occupies bits [(m*N_DIGITS+d)*SEG_W +: SEG_W].
- hex_out, out, N_DIGITS*SEG_W: to display; digit d at [d*SEG_W +: SEG_W].
- keys_out_n, out, N_MODES*N_KEYS: per-mode key copies; mode m at [m*N_KEYS +: N_KEYS].
- mode_idx, out, MIW: current mode index.
- mode_onehot, out, N_MODES: one-hot of mode_idx.
- mode_change, out, 1: one-cycle pulse on the cycle BLANK is entered.

Behaviour:
- Reset (rst_n=0 at a clk edge), all outputs registered:
  - mode_idx=0, mode_onehot=1, state=ACTIVE.
  - hex_out all ones, keys_out_n all ones, mode_change=0.
  - Button history register = 1, blank counter = 0.
- Button edge: press = (btn_q==1 && mode_btn_n==0); btn_q <= mode_btn_n every cycle. A held button yields exactly one press.
- ACTIVE state:
  - hex_out <= source[mode_idx] (1-cycle latency).
  - keys_out_n slice[mode_idx] <= keys_n; every other slice <= all ones.
  - On press:
    - mode_idx <= mode_idx+1, wrapping N_MODES-1 -> 0; mode_onehot follows.
    - cnt <= BLANK_CYCLES-1; state <= BLANK; mode_change <= 1.
    - hex_out and all keys_out_n <= all ones.
  - Press wins over any simultaneous key activity; that key state is not forwarded.
- BLANK state:
  - hex_out all ones; all keys_out_n all ones; presses ignored.
  - cnt decrements each cycle.
  - When cnt==0: go to ACTIVE if &keys_n==1, else go to HOLD.
- HOLD state:
  - hex_out <= source[mode_idx]; all keys_out_n all ones; presses ignored.
  - Exit to ACTIVE on the first cycle &keys_n==1.
  - Key forwarding starts the cycle after that.
- Blank duration: BLANK_CYCLES cycles of all-ones output, counted from the first blank cycle.
- mode_change is high for exactly one cycle per accepted press, otherwise 0.
- Reset mid-BLANK or mid-HOLD: returns to mode 0 / ACTIVE with reset values. No pending switch survives.
- A mode_idx value >= N_MODES is unreachable. If it is forced, the next press wraps it to 0 and the display shows source 0.

Decomposition:
- Shared package hex_mode_pkg holds:
  - The state enum {ACTIVE, BLANK, HOLD}.
  - Localparam function blank_seg(SEG_W) returning all ones.
  - The slice-offset helper functions.
- Sub-module fall_edge_det: a registered falling-edge detector, synchronous active-low reset that sets its history register to 1. It is reusable by other watch blocks.

Test Plan:
Defaults throughout: N_MODES=3, N_DIGITS=6, SEG_W=7, N_KEYS=3, BLANK_CYCLES=4.
1. Reset, then source0 = 42'h0123456789A, keys_n=3'b110 -> hex_out = 42'h0123456789A one cycle later; keys_out_n = 9'b111_111_110; mode_idx=0.
2. Single press (button low 10 cycles) -> mode_change high for 1 cycle; hex_out all ones for exactly 4 cycles; then source1 shown; mode_idx=1; mode_onehot=3'b010.
3. Three separate presses -> mode_idx sequence 1, 2, 0 (wrap); mode_change pulses exactly 3 times.
4. KEY0 held low from before the press until 10 cycles after blanking ends -> state HOLD, source1 displayed, keys_out_n all ones throughout. Release -> keys forwarded to slice 1 the following cycle.
5. Press during BLANK and during HOLD -> ignored; mode_idx advances only once.
6. rst_n low for 1 cycle on the 2nd blank cycle -> mode_idx=0, ACTIVE; next cycle shows source0 and forwards keys to slice 0.

Source files
------------

// File: rtl/hex_mode_pkg.sv
// Shared types and slice helpers for the hex/key mode router.
package hex_mode_pkg;

  typedef enum logic [1:0] {ACTIVE, BLANK, HOLD} state_e;

  // Segments are active-low, so a blank digit is all ones.
  function automatic logic [63:0] blank_seg(input int seg_w);
    return ~64'd0 >> (64 - seg_w);
  endfunction

  function automatic int src_off(input int m, input int d, input int n_digits, input int seg_w);
    return (m * n_digits + d) * seg_w;
  endfunction

  function automatic int key_off(input int m, input int n_keys);
    return m * n_keys;
  endfunction

endpackage

// File: rtl/fall_edge_det.sv
// Registered falling-edge detector; history resets high so a held-low input
// coming out of reset registers as one edge.
module fall_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_n,
  output logic fall
);
  logic hist_q, hist_d;

  always_comb hist_d = d_n;

  always_ff @(posedge clk) begin
    if (!rst_n) hist_q <= 1'b1;
    else        hist_q <= hist_d;
  end

  assign fall = hist_q & ~d_n;
endmodule

// File: rtl/hex_mode_router.sv
// Clocked display/key router: cycles N_MODES sources on a button press with a
// blanking interval and a key-release holdoff before keys reach the new mode.
module hex_mode_router
  import hex_mode_pkg::*;
#(
  parameter int N_MODES      = 3,
  parameter int N_DIGITS     = 6,
  parameter int SEG_W        = 7,
  parameter int N_KEYS       = 3,
  parameter int BLANK_CYCLES = 4,
  parameter int MIW          = $clog2(N_MODES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mode_btn_n,
  input  logic [N_KEYS-1:0]             keys_n,
  input  logic [N_MODES*N_DIGITS*SEG_W-1:0] hex_in,
  output logic [N_DIGITS*SEG_W-1:0]     hex_out,
  output logic [N_MODES*N_KEYS-1:0]     keys_out_n,
  output logic [MIW-1:0]                mode_idx,
  output logic [N_MODES-1:0]            mode_onehot,
  output logic                          mode_change
);
  localparam int CW = $clog2(BLANK_CYCLES + 1);
  localparam int HW = N_DIGITS * SEG_W;
  localparam int KW = N_MODES * N_KEYS;
  localparam logic [SEG_W-1:0] BLANK_DIG = SEG_W'(blank_seg(SEG_W));
  localparam logic [HW-1:0]    ALL_BLANK = {N_DIGITS{BLANK_DIG}};

  state_e               state_q, state_d;
  logic [MIW-1:0]       mode_idx_q, mode_idx_d, next_idx;
  logic [N_MODES-1:0]   onehot_q, onehot_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [HW-1:0]        hex_q, hex_d, src_sel;
  logic [KW-1:0]        keys_q, keys_d, fwd_keys;
  logic                 mc_q, mc_d;
  logic                 press;

  fall_edge_det u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .d_n   (mode_btn_n),
    .fall  (press)
  );

  // An out-of-range index selects nothing and shows blank.
  always_comb begin
    src_sel  = ALL_BLANK;
    fwd_keys = '1;
    for (int m = 0; m < N_MODES; m++) begin
      if (mode_idx_q == MIW'(m)) begin
        for (int d = 0; d < N_DIGITS; d++)
          src_sel[d*SEG_W +: SEG_W] = hex_in[src_off(m, d, N_DIGITS, SEG_W) +: SEG_W];
        fwd_keys[key_off(m, N_KEYS) +: N_KEYS] = keys_n;
      end
    end
    next_idx = (mode_idx_q >= MIW'(N_MODES - 1)) ? '0 : mode_idx_q + MIW'(1);
  end

  always_comb begin
    state_d    = state_q;
    mode_idx_d = mode_idx_q;
    cnt_d      = cnt_q;
    hex_d      = ALL_BLANK;
    keys_d     = '1;
    mc_d       = 1'b0;
    case (state_q)
      ACTIVE: begin
        if (press) begin
          mode_idx_d = next_idx;
          cnt_d      = CW'(BLANK_CYCLES - 1);
          state_d    = BLANK;
          mc_d       = 1'b1;
        end else begin
          hex_d  = src_sel;
          keys_d = fwd_keys;
        end
      end
      BLANK: begin
        if (cnt_q == '0) begin
          // Unblank on the exit edge so the blank lasts exactly BLANK_CYCLES.
          hex_d   = src_sel;
          state_d = (&keys_n) ? ACTIVE : HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        hex_d = src_sel;
        if (&keys_n) state_d = ACTIVE;
      end
      default: state_d = ACTIVE;
    endcase

    onehot_d = '0;
    for (int m = 0; m < N_MODES; m++)
      if (mode_idx_d == MIW'(m)) onehot_d[m] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ACTIVE;
      mode_idx_q <= '0;
      onehot_q   <= N_MODES'(1);
      cnt_q      <= '0;
      hex_q      <= ALL_BLANK;
      keys_q     <= '1;
      mc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_idx_q <= mode_idx_d;
      onehot_q   <= onehot_d;
      cnt_q      <= cnt_d;
      hex_q      <= hex_d;
      keys_q     <= keys_d;
      mc_q       <= mc_d;
    end
  end

  assign hex_out     = hex_q;
  assign keys_out_n  = keys_q;
  assign mode_idx    = mode_idx_q;
  assign mode_onehot = onehot_q;
  assign mode_change = mc_q;
endmodule

// File: tb/tb_hex_mode_router.sv
// Directed scoreboard bench: each driven cycle queues its expected outputs,
// a negedge monitor pops and compares them.
module tb_hex_mode_router;
  localparam logic [41:0] SRC0 = 42'h0123456789A;
  localparam logic [41:0] SRC1 = 42'h1F0F0F0F0F0;
  localparam logic [41:0] SRC2 = 42'h0ABCDEF0123;
  localparam logic [41:0] ONES = '1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode_btn_n = 1'b1;
  logic [2:0]  keys_n = 3'b111;
  logic [125:0] hex_in;
  logic [41:0] hex_out;
  logic [8:0]  keys_out_n;
  logic [1:0]  mode_idx;
  logic [2:0]  mode_onehot;
  logic        mode_change;

  int checks = 0;
  int errors = 0;
  int mc_seen = 0;

  typedef struct {
    bit          ch;
    logic [41:0] hex;
    bit          ck;
    logic [8:0]  keys;
    bit          ci;
    logic [1:0]  idx;
    logic        mc;
  } exp_t;

  exp_t q[$];

  hex_mode_router dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_btn_n  (mode_btn_n),
    .keys_n      (keys_n),
    .hex_in      (hex_in),
    .hex_out     (hex_out),
    .keys_out_n  (keys_out_n),
    .mode_idx    (mode_idx),
    .mode_onehot (mode_onehot),
    .mode_change (mode_change)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(bit ch, logic [41:0] h, bit ck, logic [8:0] k,
                              bit ci, logic [1:0] i, logic mc);
    exp_t e;
    e.ch = ch; e.hex = h; e.ck = ck; e.keys = k; e.ci = ci; e.idx = i; e.mc = mc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mode_change === 1'b1) mc_seen++;
    if (q.size() > 0) begin
      exp_t e;
      logic [2:0] oh;
      e = q.pop_front();
      if (e.ch) chk("hex_out", 64'(hex_out), 64'(e.hex));
      if (e.ck) chk("keys_out_n", 64'(keys_out_n), 64'(e.keys));
      if (e.ci) begin
        oh = 3'b001 << e.idx;
        chk("mode_idx", 64'(mode_idx), 64'(e.idx));
        chk("mode_onehot", 64'(mode_onehot), 64'(oh));
      end
      chk("mode_change", 64'(mode_change), 64'(e.mc));
    end
  end

  task automatic cyc(input logic r, input logic b, input logic [2:0] k, input exp_t e);
    rst_n = r; mode_btn_n = b; keys_n = k;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic press_seq(input logic [1:0] ni, input logic [41:0] s);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, (i < 2) ? 1'b0 : 1'b1, 3'b111,
          mk(1, (i < 4) ? ONES : s, 1, 9'h1FF, 1, ni, i == 0));
  endtask

  initial begin
    int mc0;
    hex_in = {SRC2, SRC1, SRC0};

    // 1: reset then forward source 0 and keys to slice 0
    cyc(0, 1, 3'b111, mk(1, ONES, 1, 9'h1FF, 1, 2'd0, 0));
    cyc(1, 1, 3'b110, mk(1, SRC0, 1, 9'b111_111_110, 1, 2'd0, 0));
    cyc(1, 1, 3'b111, mk(1, SRC0, 1, 9'h1FF, 1, 2'd0, 0));

    // 2: button held 10 cycles -> one switch, 4 blank cycles
    for (int i = 0; i < 10; i++)
      cyc(1, 0, 3'b111, mk(1, (i < 4) ? ONES : SRC1, 1, 9'h1FF, 1, 2'd1, i == 0));
    cyc(1, 1, 3'b111, mk(1, SRC1, 1, 9'h1FF, 1, 2'd1, 0));

    // 3: from reset, three presses -> 1, 2, 0
    cyc(0, 1, 3'b111, mk(1, ONES, 1, 9'h1FF, 1, 2'd0, 0));
    cyc(1, 1, 3'b111, mk(1, SRC0, 1, 9'h1FF, 1, 2'd0, 0));
    @(negedge clk); #1;
    mc0 = mc_seen;
    press_seq(2'd1, SRC1);
    press_seq(2'd2, SRC2);
    press_seq(2'd0, SRC0);
    @(negedge clk); #1;
    chk("mc_pulse_count", 64'(mc_seen - mc0), 64'd3);

    // 4: KEY0 held across the switch -> HOLD until release
    cyc(1, 1, 3'b110, mk(1, SRC0, 1, 9'b111_111_110, 1, 2'd0, 0));
    cyc(1, 0, 3'b110, mk(1, ONES, 1, 9'h1FF, 1, 2'd1, 1));
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 3'b110, mk(1, ONES, 1, 9'h1FF, 1, 2'd1, 0));
    for (int i = 0; i < 10; i++)
      cyc(1, 1, 3'b110, mk(1, SRC1, 1, 9'h1FF, 1, 2'd1, 0));
    cyc(1, 1, 3'b111, mk(1, SRC1, 1, 9'h1FF, 1, 2'd1, 0));
    cyc(1, 1, 3'b101, mk(1, SRC1, 1, 9'b111_101_111, 1, 2'd1, 0));
    cyc(1, 1, 3'b111, mk(1, SRC1, 1, 9'h1FF, 1, 2'd1, 0));

    // 5: presses during BLANK and HOLD are ignored
    cyc(1, 0, 3'b111, mk(1, ONES, 1, 9'h1FF, 1, 2'd2, 1));
    cyc(1, 1, 3'b111, mk(1, ONES, 1, 9'h1FF, 1, 2'd2, 0));
    cyc(1, 0, 3'b110, mk(1, ONES, 1, 9'h1FF, 1, 2'd2, 0));
    cyc(1, 0, 3'b110, mk(1, ONES, 1, 9'h1FF, 1, 2'd2, 0));
    cyc(1, 1, 3'b110, mk(1, SRC2, 1, 9'h1FF, 1, 2'd2, 0));
    cyc(1, 0, 3'b110, mk(1, SRC2, 1, 9'h1FF, 1, 2'd2, 0));
    cyc(1, 0, 3'b111, mk(1, SRC2, 1, 9'h1FF, 1, 2'd2, 0));
    cyc(1, 1, 3'b111, mk(1, SRC2, 1, 9'h1FF, 1, 2'd2, 0));

    // 6: reset on the 2nd blank cycle drops the pending switch
    cyc(0, 1, 3'b111, mk(1, ONES, 1, 9'h1FF, 1, 2'd0, 0));
    cyc(1, 1, 3'b111, mk(1, SRC0, 1, 9'h1FF, 1, 2'd0, 0));
    cyc(1, 0, 3'b111, mk(1, ONES, 1, 9'h1FF, 1, 2'd1, 1));
    cyc(0, 0, 3'b111, mk(1, ONES, 1, 9'h1FF, 1, 2'd0, 0));
    cyc(1, 1, 3'b011, mk(1, SRC0, 1, 9'b111_111_011, 1, 2'd0, 0));
    cyc(1, 1, 3'b111, mk(1, SRC0, 1, 9'h1FF, 1, 2'd0, 0));

    @(negedge clk); #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
